frame_timing_source: RTL and testbench
======================================

# frame_timing_source

Drives every frame the renderer draws. It produces the 1024x768@60 pixel raster (`hcount`, `vcount`, `hsync`, `vsync`, `blank`) and a frame-coherent snapshot of game state. Game logic writes state into the block at any time. The block hands the renderer a copy that changes only at the start of vertical blank, so no frame shows a half-updated grid or player set. It sits between the game FSM and the graphics pipeline, on the pixel clock.

## Interface
Parameters:
- `H_ACTIVE`, 1024, visible pixels per line
- `H_FP`, 24, horizontal front porch
- `H_SYNC`, 136, hsync width
- `H_BP`, 160, horizontal back porch
- `V_ACTIVE`, 768, visible lines
- `V_FP`, 3, vertical front porch
- `V_SYNC`, 6, vsync width
- `V_BP`, 29, vertical back porch

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - `clock`  in  1  pixel clock (65 MHz)
  - `reset`  in  1  asynchronous, active-low reset
- Game-state inputs:
  - `state_valid`  in  1  write strobe for `*_in` state
  - `object_grid_in`  in  [7:0][12:0][3:0]  object grid
  - `player_in`  in  [3:0] player_t  x[8:0], y[8:0], direction[1:0], state[3:0] per player
- Raster outputs:
  - `hcount`  out  11  current pixel column
  - `vcount`  out  10  current line
  - `hsync`  out  1  active-low
  - `vsync`  out  1  active-low
  - `blank`  out  1  high outside the active area
- Snapshot and status outputs:
  - `object_grid`  out  [7:0][12:0][3:0]  display snapshot
  - `player`  out  [3:0] player_t  display snapshot
  - `vblank_start`  out  1  one-cycle pulse on the swap cycle
  - `snapshot_fresh`  out  1  last swap carried new data
  - `frame_count`  out  16  completed frames, wraps

## Operation
- Line total is 1344 pixels; frame total is 806 lines.
- Counters:
  - `hcount` runs 0..1343 then wraps to 0.
  - `vcount` advances only when `hcount` wraps, and runs 0..805 then wraps to 0.
- Decode (from the same count values presented on the outputs):
  - `hsync` = 0 iff `hcount` is in 1048..1183.
  - `vsync` = 0 iff `vcount` is in 771..776.
  - `blank` = (`hcount` >= 1024) or (`vcount` >= 768).
- Shadow register:
  - Every cycle with `state_valid`=1 loads `*_in` into the shadow and sets `pending`=1.
  - The last write before the swap wins.
- Swap cycle: `hcount`=0 and `vcount`=768. On it:
  - The display registers take the shadow contents.
  - `snapshot_fresh` takes the value of `pending`.
  - `pending` clears.
  - `vblank_start`=1.
- Swap bypass: if `state_valid`=1 in the swap cycle, the display registers take `*_in` directly, `snapshot_fresh`=1, and `pending` ends at 0.
- No update since the last swap: the display registers hold their contents and `snapshot_fresh`=0.
- `frame_count` increments when `vcount` wraps 805 to 0, and wraps 0xFFFF to 0.

## Timing
- All outputs are registered. Raster outputs are mutually consistent in the same cycle; there is zero skew between count and decode.
- Reset values:
  - `hcount`=0, `vcount`=0
  - `hsync`=1, `vsync`=1, `blank`=0
  - shadow, display, `pending`, `snapshot_fresh`, `vblank_start`, `frame_count` = 0
- First cycle after reset release presents (`hcount`,`vcount`) = (0,0) and then advances by 1 per clock.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronous). Any pending write is discarded.
- Snapshot outputs change only on the clock edge that presents the swap cycle. They are stable through the entire active region.
- Write-to-display latency: from the cycle after a write to the next swap, at most 1 frame (1,083,264 cycles).

## Structure
- Package `frame_pkg`:
  - `player_t` packed struct
  - timing constants: H_TOTAL=1344, V_TOTAL=806, sync start/end positions
  - `GRID_W`=13, `GRID_H`=8
- Sub-module `raster_counter`: counters plus sync/blank decode, carrying the parameters and a `frame_wrap` strobe.
- Top level: shadow/display registers, the `pending` flag, and the frame counter.

## Test plan
- Release reset and run 2 frames:
  - `hcount` wraps after 1343 and `vcount` after 805.
  - `hsync` low for exactly 136 cycles starting at `hcount`=1048.
  - `vsync` low for lines 771..776.
  - `frame_count`=2.
- Write grid cell [0][0]=4'h3 at `vcount`=100: output remains 0 until (0,768), then reads 4'h3 with `vblank_start`=1 and `snapshot_fresh`=1.
- Write player0 x=9'd50 then x=9'd60 in the same frame: the swap shows x=60.
- Assert `state_valid` with player0 y=9'd77 exactly on the swap cycle: display shows y=77 that cycle, `snapshot_fresh`=1, and the next swap has `snapshot_fresh`=0 and unchanged data.
- Assert `reset`=0 at (500,300) with `pending`=1, then release: counters restart at (0,0), snapshot outputs are 0, and the first swap has `snapshot_fresh`=0.
- Preload `frame_count`=0xFFFF by running or forcing the counter: the next `vcount` wrap gives 0.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared types and default 1024x768@60 timing constants for the frame timing source.
package frame_pkg;

    localparam int GRID_W = 13;
    localparam int GRID_H = 8;

    localparam int H_TOTAL      = 1344;
    localparam int V_TOTAL      = 806;
    localparam int H_SYNC_START = 1048;
    localparam int H_SYNC_END   = 1183;
    localparam int V_SYNC_START = 771;
    localparam int V_SYNC_END   = 776;

    typedef struct packed {
        logic [8:0] x;
        logic [8:0] y;
        logic [1:0] direction;
        logic [3:0] state;
    } player_t;

    function automatic logic in_window(input int count, input int first, input int last);
        return (count >= first) && (count <= last);
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Pixel/line counters with registered sync and blank decode, plus strobes
// that flag the edge which wraps the frame and the edge which enters vertical blank.
module raster_counter
    import frame_pkg::*;
#(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29
) (
    input  logic        clock,
    input  logic        reset,
    output logic [10:0] hcount,
    output logic [9:0]  vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic        frame_wrap,
    output logic        swap_next
);

    localparam int HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_FIRST = H_ACTIVE + H_FP;
    localparam int HS_LAST  = HS_FIRST + H_SYNC - 1;
    localparam int VS_FIRST = V_ACTIVE + V_FP;
    localparam int VS_LAST  = VS_FIRST + V_SYNC - 1;

    localparam logic [10:0] H_LAST      = 11'(HT - 1);
    localparam logic [9:0]  V_LAST      = 10'(VT - 1);
    localparam logic [9:0]  V_SWAP_PREV = 10'(V_ACTIVE - 1);

    logic [10:0] hcount_q, hcount_d;
    logic [9:0]  vcount_q, vcount_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        blank_q, blank_d;
    logic        line_end;

    assign line_end   = (hcount_q == H_LAST);
    assign frame_wrap = line_end && (vcount_q == V_LAST);
    assign swap_next  = line_end && (vcount_q == V_SWAP_PREV);

    // Decode from the next count so counts and sync/blank land on the same edge.
    always_comb begin
        hcount_d = line_end ? 11'd0 : hcount_q + 11'd1;
        vcount_d = vcount_q;
        if (line_end) begin
            vcount_d = (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;
        end
        hsync_d = !in_window(int'(hcount_d), HS_FIRST, HS_LAST);
        vsync_d = !in_window(int'(vcount_d), VS_FIRST, VS_LAST);
        blank_d = (int'(hcount_d) >= H_ACTIVE) || (int'(vcount_d) >= V_ACTIVE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hcount_q <= 11'd0;
            vcount_q <= 10'd0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            blank_q  <= 1'b0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            blank_q  <= blank_d;
        end
    end

    assign hcount = hcount_q;
    assign vcount = vcount_q;
    assign hsync  = hsync_q;
    assign vsync  = vsync_q;
    assign blank  = blank_q;

endmodule

// File: rtl/frame_timing_source.sv
// Raster timing plus a double-buffered game-state snapshot that only swaps
// on entry to vertical blank, and a free-running completed-frame counter.
module frame_timing_source
    import frame_pkg::*;
#(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               state_valid,
    input  logic [GRID_H-1:0][GRID_W-1:0][3:0] object_grid_in,
    input  player_t [3:0]                      player_in,
    output logic [10:0]                        hcount,
    output logic [9:0]                         vcount,
    output logic                               hsync,
    output logic                               vsync,
    output logic                               blank,
    output logic [GRID_H-1:0][GRID_W-1:0][3:0] object_grid,
    output player_t [3:0]                      player,
    output logic                               vblank_start,
    output logic                               snapshot_fresh,
    output logic [15:0]                        frame_count
);

    logic frame_wrap;
    logic swap_next;

    raster_counter #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_raster (
        .clock      (clock),
        .reset      (reset),
        .hcount     (hcount),
        .vcount     (vcount),
        .hsync      (hsync),
        .vsync      (vsync),
        .blank      (blank),
        .frame_wrap (frame_wrap),
        .swap_next  (swap_next)
    );

    logic [GRID_H-1:0][GRID_W-1:0][3:0] shadow_grid_q, shadow_grid_d;
    logic [GRID_H-1:0][GRID_W-1:0][3:0] grid_q, grid_d;
    player_t [3:0]                      shadow_player_q, shadow_player_d;
    player_t [3:0]                      player_q, player_d;
    logic                               pending_q, pending_d;
    logic                               fresh_q, fresh_d;
    logic                               vblank_start_q, vblank_start_d;
    logic [15:0]                        frame_count_q, frame_count_d;

    // A write landing on the swap edge bypasses the shadow straight to the display.
    always_comb begin
        shadow_grid_d   = shadow_grid_q;
        shadow_player_d = shadow_player_q;
        grid_d          = grid_q;
        player_d        = player_q;
        pending_d       = pending_q;
        fresh_d         = fresh_q;
        frame_count_d   = frame_count_q;
        vblank_start_d  = swap_next;

        if (state_valid) begin
            shadow_grid_d   = object_grid_in;
            shadow_player_d = player_in;
            pending_d       = 1'b1;
        end

        if (swap_next) begin
            if (state_valid) begin
                grid_d   = object_grid_in;
                player_d = player_in;
            end else if (pending_q) begin
                grid_d   = shadow_grid_q;
                player_d = shadow_player_q;
            end
            fresh_d   = state_valid || pending_q;
            pending_d = 1'b0;
        end

        if (frame_wrap) begin
            frame_count_d = frame_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shadow_grid_q   <= '0;
            shadow_player_q <= '0;
            grid_q          <= '0;
            player_q        <= '0;
            pending_q       <= 1'b0;
            fresh_q         <= 1'b0;
            vblank_start_q  <= 1'b0;
            frame_count_q   <= 16'd0;
        end else begin
            shadow_grid_q   <= shadow_grid_d;
            shadow_player_q <= shadow_player_d;
            grid_q          <= grid_d;
            player_q        <= player_d;
            pending_q       <= pending_d;
            fresh_q         <= fresh_d;
            vblank_start_q  <= vblank_start_d;
            frame_count_q   <= frame_count_d;
        end
    end

    assign object_grid    = grid_q;
    assign player         = player_q;
    assign vblank_start   = vblank_start_q;
    assign snapshot_fresh = fresh_q;
    assign frame_count    = frame_count_q;

endmodule

// File: tb/tb_frame_timing_source.sv
// Directed bench on a shrunken raster: 28 pixels/line (sync low 20..24),
// 20 lines/frame (sync low 14..16, swap at line 12).
module tb_frame_timing_source;
    import frame_pkg::*;

    logic                               clock;
    logic                               reset;
    logic                               state_valid;
    logic [GRID_H-1:0][GRID_W-1:0][3:0] object_grid_in;
    player_t [3:0]                      player_in;
    logic [10:0]                        hcount;
    logic [9:0]                         vcount;
    logic                               hsync;
    logic                               vsync;
    logic                               blank;
    logic [GRID_H-1:0][GRID_W-1:0][3:0] object_grid;
    player_t [3:0]                      player;
    logic                               vblank_start;
    logic                               snapshot_fresh;
    logic [15:0]                        frame_count;

    int n_checks = 0;
    int n_errors = 0;
    int m_h = 0;
    int m_v = 0;

    frame_timing_source #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(5), .H_BP(3),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(3), .V_BP(3)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .state_valid    (state_valid),
        .object_grid_in (object_grid_in),
        .player_in      (player_in),
        .hcount         (hcount),
        .vcount         (vcount),
        .hsync          (hsync),
        .vsync          (vsync),
        .blank          (blank),
        .object_grid    (object_grid),
        .player         (player),
        .vblank_start   (vblank_start),
        .snapshot_fresh (snapshot_fresh),
        .frame_count    (frame_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge; the model tracks position.
    task automatic tick();
        @(posedge clock);
        #1;
        if (m_h == 27) begin
            m_h = 0;
            m_v = (m_v == 19) ? 0 : m_v + 1;
        end else begin
            m_h = m_h + 1;
        end
    endtask

    task automatic advance_to(input int h, input int v);
        int guard;
        guard = 0;
        while (!(m_h == h && m_v == v) && guard < 2000) begin
            tick();
            guard++;
        end
    endtask

    initial begin
        int bad_pos, bad_hs, bad_vs, bad_blank, bad_vbs;
        int hs_low_line0, hs_first, vs_low_cycles, vs_first, vs_last, h_max, v_max;
        logic exp_hs, exp_vs, exp_blank, exp_vbs;

        reset          = 1'b0;
        state_valid    = 1'b0;
        object_grid_in = '0;
        player_in      = '0;

        #12;
        check_output("rst_hcount", 32'(hcount), 32'd0);
        check_output("rst_vcount", 32'(vcount), 32'd0);
        check_output("rst_hsync", 32'(hsync), 32'd1);
        check_output("rst_vsync", 32'(vsync), 32'd1);
        check_output("rst_blank", 32'(blank), 32'd0);
        check_output("rst_vblank_start", 32'(vblank_start), 32'd0);
        check_output("rst_fresh", 32'(snapshot_fresh), 32'd0);
        check_output("rst_frame_count", 32'(frame_count), 32'd0);

        @(posedge clock);
        #1;
        reset = 1'b1;
        m_h = 0;
        m_v = 0;
        check_output("first_hcount", 32'(hcount), 32'd0);

        // Two full frames, tracking raster decode against hand-placed windows.
        bad_pos = 0; bad_hs = 0; bad_vs = 0; bad_blank = 0; bad_vbs = 0;
        hs_low_line0 = 0; hs_first = -1; vs_low_cycles = 0; vs_first = -1; vs_last = -1;
        h_max = 0; v_max = 0;
        for (int c = 0; c < 2 * 560; c++) begin
            tick();
            exp_hs    = !(m_h >= 20 && m_h <= 24);
            exp_vs    = !(m_v >= 14 && m_v <= 16);
            exp_blank = (m_h >= 16) || (m_v >= 12);
            exp_vbs   = (m_h == 0) && (m_v == 12);
            if (int'(hcount) != m_h || int'(vcount) != m_v) bad_pos++;
            if (hsync !== exp_hs) bad_hs++;
            if (vsync !== exp_vs) bad_vs++;
            if (blank !== exp_blank) bad_blank++;
            if (vblank_start !== exp_vbs) bad_vbs++;
            if (int'(hcount) > h_max) h_max = int'(hcount);
            if (int'(vcount) > v_max) v_max = int'(vcount);
            if (c < 28 && hsync === 1'b0) begin
                hs_low_line0++;
                if (hs_first < 0) hs_first = int'(hcount);
            end
            if (c < 560 && vsync === 1'b0) begin
                vs_low_cycles++;
                if (vs_first < 0) vs_first = int'(vcount);
                vs_last = int'(vcount);
            end
        end
        check_output("pos_track", 32'(bad_pos), 32'd0);
        check_output("hsync_track", 32'(bad_hs), 32'd0);
        check_output("vsync_track", 32'(bad_vs), 32'd0);
        check_output("blank_track", 32'(bad_blank), 32'd0);
        check_output("vblank_start_track", 32'(bad_vbs), 32'd0);
        check_output("hcount_max", 32'(h_max), 32'd27);
        check_output("vcount_max", 32'(v_max), 32'd19);
        check_output("hsync_low_len", 32'(hs_low_line0), 32'd5);
        check_output("hsync_low_first", 32'(hs_first), 32'd20);
        check_output("vsync_low_cycles", 32'(vs_low_cycles), 32'd84);
        check_output("vsync_first_line", 32'(vs_first), 32'd14);
        check_output("vsync_last_line", 32'(vs_last), 32'd16);
        check_output("frames_after_two", 32'(frame_count), 32'd2);
        check_output("wrap_hcount", 32'(hcount), 32'd0);
        check_output("wrap_vcount", 32'(vcount), 32'd0);

        // Grid write mid-frame only appears at the swap.
        advance_to(0, 5);
        object_grid_in[0][0] = 4'h3;
        state_valid = 1'b1;
        tick();
        state_valid = 1'b0;
        check_output("grid_hold_after_write", 32'(object_grid[0][0]), 32'h0);
        advance_to(27, 11);
        check_output("grid_hold_before_swap", 32'(object_grid[0][0]), 32'h0);
        check_output("vbs_before_swap", 32'(vblank_start), 32'd0);
        tick();
        check_output("grid_swap_value", 32'(object_grid[0][0]), 32'h3);
        check_output("grid_swap_vbs", 32'(vblank_start), 32'd1);
        check_output("grid_swap_fresh", 32'(snapshot_fresh), 32'd1);
        tick();
        check_output("vbs_one_cycle", 32'(vblank_start), 32'd0);
        check_output("grid_after_swap", 32'(object_grid[0][0]), 32'h3);

        // Last write before the swap wins.
        advance_to(0, 2);
        player_in[0].x = 9'd50;
        state_valid = 1'b1;
        tick();
        state_valid = 1'b0;
        advance_to(10, 4);
        player_in[0].x = 9'd60;
        state_valid = 1'b1;
        tick();
        state_valid = 1'b0;
        player_in[0].x = 9'd99;
        advance_to(27, 11);
        check_output("p0x_before_swap", 32'(player[0].x), 32'd0);
        tick();
        check_output("p0x_last_wins", 32'(player[0].x), 32'd60);
        check_output("p0x_fresh", 32'(snapshot_fresh), 32'd1);
        check_output("grid_kept", 32'(object_grid[0][0]), 32'h3);

        // Write sampled on the swap edge goes straight to the display.
        advance_to(27, 11);
        player_in[0].x = 9'd60;
        player_in[0].y = 9'd77;
        state_valid = 1'b1;
        tick();
        state_valid = 1'b0;
        player_in[0].y = 9'd5;
        check_output("bypass_y", 32'(player[0].y), 32'd77);
        check_output("bypass_x", 32'(player[0].x), 32'd60);
        check_output("bypass_fresh", 32'(snapshot_fresh), 32'd1);
        check_output("bypass_vbs", 32'(vblank_start), 32'd1);
        advance_to(5, 3);
        check_output("bypass_stable_active", 32'(player[0].y), 32'd77);
        advance_to(0, 12);
        check_output("noupd_fresh", 32'(snapshot_fresh), 32'd0);
        check_output("noupd_y", 32'(player[0].y), 32'd77);
        check_output("noupd_vbs", 32'(vblank_start), 32'd1);

        // Asynchronous reset mid-frame drops a pending write.
        advance_to(10, 5);
        player_in[0].x = 9'd123;
        state_valid = 1'b1;
        tick();
        state_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_output("async_rst_hcount", 32'(hcount), 32'd0);
        check_output("async_rst_vcount", 32'(vcount), 32'd0);
        check_output("async_rst_p0x", 32'(player[0].x), 32'd0);
        check_output("async_rst_grid", 32'(object_grid[0][0]), 32'h0);
        check_output("async_rst_frames", 32'(frame_count), 32'd0);
        check_output("async_rst_hsync", 32'(hsync), 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        m_h = 0;
        m_v = 0;
        check_output("rerelease_hcount", 32'(hcount), 32'd0);
        tick();
        check_output("rerelease_advance", 32'(hcount), 32'd1);
        advance_to(0, 12);
        check_output("post_rst_swap_vbs", 32'(vblank_start), 32'd1);
        check_output("post_rst_swap_fresh", 32'(snapshot_fresh), 32'd0);
        check_output("post_rst_swap_p0x", 32'(player[0].x), 32'd0);

        // Frame counter wrap from 0xFFFF.
        force dut.frame_count_q = 16'hFFFF;
        tick();
        release dut.frame_count_q;
        advance_to(27, 19);
        check_output("frames_preloaded", 32'(frame_count), 32'hFFFF);
        tick();
        check_output("frames_wrap_zero", 32'(frame_count), 32'h0);
        check_output("frames_wrap_vcount", 32'(vcount), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
